// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: byte FIFO plus IDLE/SEND/GAP sequencer feeding a UART transmitter
// through a tx_en_sig/tx_data/tx_done handshake.
module uart_tx_fifo_ctrl #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_en_sig,
    output logic [7:0]        tx_data,
    input  logic              tx_done
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          mem_q [DEPTH];
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                tx_en_q, tx_en_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                wr_ok_c;
    logic                pop_c;

    // Occupancy flags decode straight from the registered count
    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
    end

    // Next-state, pointer, count and handshake logic
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        tx_en_d    = tx_en_q;
        tx_data_d  = tx_data_q;
        pop_c      = 1'b0;
        // Registered full gates writes, so a same-cycle pop never frees a slot early
        wr_ok_c    = wr_en && !full;
        overflow_d = wr_en && full;

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop_c     = 1'b1;
                    tx_en_d   = 1'b1;
                    tx_data_d = mem_q[rptr_q];
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_done) begin
                    tx_en_d = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                tx_en_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (wr_ok_c) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + ADDR_W'(1);
        end

        unique case ({wr_ok_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and handshake registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Byte storage; contents are meaningless once the pointers reset
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign tx_en_sig = tx_en_q;
    assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed self-checking bench for uart_tx_fifo_ctrl.
module tb_uart_tx_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_en_sig;
    logic [7:0] tx_data;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo_ctrl #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_en_sig (tx_en_sig),
        .tx_data   (tx_data),
        .tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic wait_tx_high(input int budget, output bit ok, output int lows);
        lows = 0;
        while (!tx_en_sig && lows < budget) begin
            step();
            lows++;
        end
        ok = tx_en_sig;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tx_done = 1'b0;
        step();
        checks++; if (count !== 5'd0)     begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (tx_en_sig !== 1'b0) begin errors++; $display("FAIL reset_tx_en got %b exp 0", tx_en_sig); end
        checks++; if (tx_data !== 8'h00)  begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_send();
        wr_en = 1'b1; wr_data = 8'h3C; step();
        wr_data = 8'hC3; step();
        wr_en = 1'b0;
        checks++; if (tx_en_sig !== 1'b1) begin errors++; $display("FAIL midrst_pre_tx_en got %b exp 1", tx_en_sig); end
        checks++; if (count !== 5'd1)     begin errors++; $display("FAIL midrst_pre_count got %0d exp 1", count); end
        checks++; if (tx_data !== 8'h3C)  begin errors++; $display("FAIL midrst_pre_tx_data got %h exp 3C", tx_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_en_sig !== 1'b0) begin errors++; $display("FAIL midrst_tx_en got %b exp 0", tx_en_sig); end
        checks++; if (count !== 5'd0)     begin errors++; $display("FAIL midrst_count got %0d exp 0", count); end
        checks++; if (tx_data !== 8'h00)  begin errors++; $display("FAIL midrst_tx_data got %h exp 00", tx_data); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL midrst_empty got %b exp 1", empty); end
        #2;
        rst_n = 1'b1;
        step();
        step();
        checks++; if (tx_en_sig !== 1'b0) begin errors++; $display("FAIL midrst_post_tx_en got %b exp 0", tx_en_sig); end
        checks++; if (count !== 5'd0)     begin errors++; $display("FAIL midrst_post_count got %0d exp 0", count); end
    endtask

    task automatic test_single_byte();
        wr_en = 1'b1; wr_data = 8'hA5; step();
        wr_en = 1'b0;
        checks++; if (tx_en_sig !== 1'b0) begin errors++; $display("FAIL single_lat1_tx_en got %b exp 0", tx_en_sig); end
        checks++; if (count !== 5'd1)     begin errors++; $display("FAIL single_lat1_count got %0d exp 1", count); end
        step();
        checks++; if (tx_en_sig !== 1'b1) begin errors++; $display("FAIL single_tx_en got %b exp 1", tx_en_sig); end
        checks++; if (tx_data !== 8'hA5)  begin errors++; $display("FAIL single_tx_data got %h exp A5", tx_data); end
        checks++; if (count !== 5'd0)     begin errors++; $display("FAIL single_count got %0d exp 0", count); end
        repeat (5) step();
        checks++; if (tx_en_sig !== 1'b1 || tx_data !== 8'hA5) begin
            errors++; $display("FAIL single_hold got en=%b data=%h exp en=1 data=A5", tx_en_sig, tx_data);
        end
        pulse_done();
        checks++; if (tx_en_sig !== 1'b0) begin errors++; $display("FAIL single_done_tx_en got %b exp 0", tx_en_sig); end
        checks++; if (count !== 5'd0)     begin errors++; $display("FAIL single_done_count got %0d exp 0", count); end
        step();
        checks++; if (tx_en_sig !== 1'b0) begin errors++; $display("FAIL single_idle_tx_en got %b exp 0", tx_en_sig); end
    endtask

    task automatic test_simultaneous_write_pop();
        bit ok;
        int lows;
        wr_en = 1'b1; wr_data = 8'h11; step();
        wr_data = 8'h22; step();
        wr_en = 1'b0;
        checks++; if (count !== 5'd1)     begin errors++; $display("FAIL simul_count got %0d exp 1", count); end
        checks++; if (tx_en_sig !== 1'b1 || tx_data !== 8'h11) begin
            errors++; $display("FAIL simul_first got en=%b data=%h exp en=1 data=11", tx_en_sig, tx_data);
        end
        pulse_done();
        wait_tx_high(10, ok, lows);
        checks++; if (!ok || tx_data !== 8'h22 || count !== 5'd0) begin
            errors++; $display("FAIL simul_second got en=%b data=%h count=%0d exp en=1 data=22 count=0", tx_en_sig, tx_data, count);
        end
        pulse_done();
        step();
    endtask

    task automatic test_burst();
        bit ok;
        int lows;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_tx_high(200, ok, lows);
            checks++; if (!ok) begin errors++; $display("FAIL burst_timeout byte %0d got en=0 exp en=1", i); end
            checks++; if (tx_data !== 8'(i)) begin errors++; $display("FAIL burst_order got %h exp %h", tx_data, 8'(i)); end
            if (i > 0) begin
                checks++; if (lows != 2) begin errors++; $display("FAIL burst_gap byte %0d got %0d exp 2", i, lows); end
            end
            repeat (98) step();
            checks++; if (tx_en_sig !== 1'b1 || tx_data !== 8'(i)) begin
                errors++; $display("FAIL burst_hold got en=%b data=%h exp en=1 data=%h", tx_en_sig, tx_data, 8'(i));
            end
            pulse_done();
        end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL burst_drained got count=%0d empty=%b exp 0/1", count, empty);
        end
        step(); step();
        checks++; if (tx_en_sig !== 1'b0 || tx_data !== 8'h0F) begin
            errors++; $display("FAIL burst_after got en=%b data=%h exp en=0 data=0F", tx_en_sig, tx_data);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int lows;
        for (int k = 0; k < 17; k++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + k); step();
        end
        checks++; if (full !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL ovf_full got full=%b count=%0d exp 1/16", full, count);
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
        checks++; if (tx_en_sig !== 1'b1 || tx_data !== 8'h40) begin
            errors++; $display("FAIL ovf_first got en=%b data=%h exp en=1 data=40", tx_en_sig, tx_data);
        end
        wr_data = 8'h51; step();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL ovf_pulse got ovf=%b count=%0d exp 1/16", overflow, count);
        end
        step();
        checks++; if (overflow !== 1'b0 || count !== 5'd16) begin
            errors++; $display("FAIL ovf_pulse_end got ovf=%b count=%0d exp 0/16", overflow, count);
        end
        // Finish frame, then write while full on the IDLE pop edge
        pulse_done();
        step();
        wr_en = 1'b1; wr_data = 8'hEE; step();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1 || count !== 5'd15) begin
            errors++; $display("FAIL ovf_pop got ovf=%b count=%0d exp 1/15", overflow, count);
        end
        checks++; if (tx_en_sig !== 1'b1 || tx_data !== 8'h41) begin
            errors++; $display("FAIL ovf_pop_data got en=%b data=%h exp en=1 data=41", tx_en_sig, tx_data);
        end
        for (int e = 8'h42; e <= 8'h50; e++) begin
            pulse_done();
            wait_tx_high(20, ok, lows);
            checks++; if (!ok || tx_data !== 8'(e)) begin
                errors++; $display("FAIL ovf_drain got en=%b data=%h exp en=1 data=%h", tx_en_sig, tx_data, 8'(e));
            end
        end
        pulse_done();
        step(); step();
        checks++; if (tx_en_sig !== 1'b0 || count !== 5'd0 || tx_data !== 8'h50) begin
            errors++; $display("FAIL ovf_end got en=%b count=%0d data=%h exp 0/0/50", tx_en_sig, count, tx_data);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int lows;
        int rd_idx = 0;
        int maxc = 0;
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 5; j++) begin
                wr_en = 1'b1; wr_data = 8'(8'h80 + b * 5 + j); step();
                if (int'(count) > maxc) maxc = int'(count);
            end
            wr_en = 1'b0;
            for (int j = 0; j < 5; j++) begin
                wait_tx_high(20, ok, lows);
                checks++; if (!ok || tx_data !== 8'(8'h80 + rd_idx)) begin
                    errors++; $display("FAIL wrap_order got en=%b data=%h exp en=1 data=%h", tx_en_sig, tx_data, 8'(8'h80 + rd_idx));
                end
                rd_idx++;
                pulse_done();
            end
        end
        checks++; if (maxc > 16 || maxc != 4) begin errors++; $display("FAIL wrap_maxcount got %0d exp 4", maxc); end
        step();
        checks++; if (count !== 5'd0 || tx_en_sig !== 1'b0) begin
            errors++; $display("FAIL wrap_end got count=%0d en=%b exp 0/0", count, tx_en_sig);
        end
    endtask

    task automatic test_spurious_done();
        pulse_done();
        checks++; if (tx_en_sig !== 1'b0 || count !== 5'd0 || tx_data !== 8'hA7) begin
            errors++; $display("FAIL spur_idle got en=%b count=%0d data=%h exp 0/0/A7", tx_en_sig, count, tx_data);
        end
        wr_en = 1'b1; wr_data = 8'h5A; step();
        wr_data = 8'h6B; step();
        wr_en = 1'b0;
        pulse_done();
        tx_done = 1'b1;
        step();
        step();
        tx_done = 1'b0;
        checks++; if (tx_en_sig !== 1'b1 || tx_data !== 8'h6B || count !== 5'd0) begin
            errors++; $display("FAIL spur_gap got en=%b data=%h count=%0d exp 1/6B/0", tx_en_sig, tx_data, count);
        end
        step();
        checks++; if (tx_en_sig !== 1'b1) begin errors++; $display("FAIL spur_hold got en=%b exp 1", tx_en_sig); end
        pulse_done();
        step(); step();
        checks++; if (tx_en_sig !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL spur_end got en=%b count=%0d exp 0/0", tx_en_sig, count);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_send();
        test_single_byte();
        test_simultaneous_write_pop();
        test_burst();
        test_overflow();
        test_wrap();
        test_spurious_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so a stuck handshake cannot hang the run
    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
